hazard_bypass_unit: RTL and testbench
=====================================

Name: hazard_bypass_unit

Overview:
- Consumer of decoded-instruction fields: receives the decode-stage instruction and tracks in-flight producers in the EXE, MEM and WB slots.
- Produces per-source bypass dependency flags and bypass selects (the bypass_t direction), plus the decode stall.
- Owns multi-cycle multiply occupancy of EXE.
- Sits between decode and the EXE-stage operand muxes.

Parameters:
- REG_ADDR_W, 5, register index width ($clog2(REG_FILE_LEN)).
- MUL_LATENCY, 4, cycles a multiply occupies EXE (>=1).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- id_valid_i  in  1  decode instruction valid
- id_src1_i  in  REG_ADDR_W  source register 1
- id_src2_i  in  REG_ADDR_W  source register 2
- id_use_src1_i  in  1  instruction reads src1
- id_use_src2_i  in  1  instruction reads src2 (0 when operand 2 is an immediate)
- id_dst_i  in  REG_ADDR_W  destination register
- id_wr_en_i  in  1  instruction writes the register file
- id_late_i  in  1  result ready only at WB (load or mul)
- id_is_mul_i  in  1  multiply instruction
- flush_i  in  1  kill decode, EXE and MEM contents
- stall_o  out  1  hold fetch/decode
- dep_src1_o  out  1  src1 is served by a bypass
- dep_src2_o  out  1  src2 is served by a bypass
- byp_sel1_o  out  2  src1 select: 00 regfile, 01 EXE, 10 MEM, 11 WB
- byp_sel2_o  out  2  src2 select, same encoding
- mul_busy_o  out  1  multiply occupying EXE

Behaviour:
- One clock, rst_n synchronous active-low. Reset clears all slot valids and the mul counter; all outputs are 0 out of reset.
- Slot record: valid, dst, wr_en, late.
- Issue condition: id_valid_i && !stall_o && !flush_i.
  - On issue, the decode record loads into EXE; otherwise EXE gets a bubble, unless a mul holds EXE.
- Slots advance every cycle: EXE->MEM->WB, and WB retires.
- Multiply handling:
  - On a mul issue, the counter loads MUL_LATENCY-1.
  - While the counter is nonzero: mul_busy_o=1, EXE holds its record, MEM receives a bubble, and the counter decrements.
  - The mul advances to MEM on the cycle the counter is 0.
  - MUL_LATENCY=1 behaves like an ALU op.
- Match rule: source s matches slot k if use_s && slot.valid && slot.wr_en && slot.dst==src_s && src_s!=0. Register x0 never matches.
- Priority: the youngest matching slot wins (EXE > MEM > WB).
- Stall conditions (combinational), stall_o=1 if any of:
  - mul_busy_o=1 (even with id_valid_i=0);
  - id_valid_i=1 and a source's youngest match is EXE or MEM with late=1.
- Non-stalled source: dep=1 and sel = the stage of the youngest match; with no match, dep=0 and sel=00.
- dep/sel are don't-care when id_valid_i=0, but are driven 0.
- flush_i:
  - Invalidates EXE and MEM at the clock edge and clears the mul counter.
  - WB still retires.
  - Decode is not issued that cycle.
  - Flush wins over mul hold.
- Reset mid-multiply: the counter clears and no stall persists.
- Both sources matching different slots are resolved independently. Both matching the same register give identical selects.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined: forwarding as described above.
- Undefined: any match in EXE, MEM or WB stalls decode. dep_src*_o=0 and byp_sel*_o=00 always; the register file is write-before-read, so WB results are visible in regfile reads.

Decomposition:
- Add to structure_pkg:
  - bypass_sel_e enum (SEL_RF, SEL_EXE, SEL_MEM, SEL_WB);
  - haz_slot_t struct (valid, dst, wr_en, late);
  - reuse bypass_t for the dep_src1/dep_src2 pair.
- Add MUL_LATENCY default to constants_pkg.
- One natural sub-module: hazard_src_match, combinational per-source priority match returning dep, sel and late-stall. Instantiate it twice.

Test Plan:
- ADD x5 issued, next cycle ADD x6,x5,x5 -> dep_src1=dep_src2=1, byp_sel1=byp_sel2=01, stall_o=0.
- LW x7 issued, next cycle ADD x8,x7,x0:
  - with forwarding: stall_o=1 for 2 cycles, then byp_sel1=11 and dep_src1=1;
  - without HAZARD_FORWARDING_EN: stall_o=1 for 3 cycles, then byp_sel1=00 and dep_src1=0.
- MUL x9 with MUL_LATENCY=4 -> mul_busy_o=1 and stall_o=1 for 3 cycles, EXE holds, MEM has bubbles, and the mul reaches MEM on cycle 4.
- ADDI x0 then ADD x1,x0,x0 -> no dependency, byp_sel=00, no stall.
- MUL in progress, flush_i=1 -> next cycle mul_busy_o=0, stall_o=0, EXE/MEM empty, and a following consumer of the mul's dst sees no match.
- ADD x3 in MEM and ADD x3 in EXE, consumer reads x3 -> byp_sel1=01 (youngest). rst_n=0 mid-sequence -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/hazard_bypass_unit_pkg.sv
// Shared types for the hazard/bypass unit.
//   bypass_sel_e : operand source select (regfile, EXE, MEM, WB)
//   haz_slot_t   : in-flight producer record held per pipeline slot
//   bypass_t     : per-source bypass dependency pair
//   RegAddrW     : register index width used by haz_slot_t
//   MulLatency   : default cycles a multiply occupies EXE
package hazard_bypass_unit_pkg;

  localparam int unsigned RegAddrW   = 5;
  localparam int unsigned MulLatency = 4;

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_EXE = 2'b01,
    SEL_MEM = 2'b10,
    SEL_WB  = 2'b11
  } bypass_sel_e;

  typedef struct packed {
    logic                valid;
    logic [RegAddrW-1:0] dst;
    logic                wr_en;
    logic                late;
  } haz_slot_t;

  typedef struct packed {
    logic src1;
    logic src2;
  } bypass_t;

  // x0 is hardwired to zero, so it never names a real producer.
  function automatic logic slot_hit(haz_slot_t slot, logic [RegAddrW-1:0] src);
    return slot.valid && slot.wr_en && (slot.dst == src) && (src != '0);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-source producer match with youngest-first priority (EXE > MEM > WB).
// Ports:
//   use_i        : instruction reads this source
//   src_i        : source register index
//   exe_i/mem_i/wb_i : in-flight slot records
//   dep_o        : some slot produces this source
//   sel_o        : stage of the youngest matching slot (SEL_RF when none)
//   late_stall_o : youngest match is in EXE or MEM and its result is not ready yet
module hazard_src_match
  import hazard_bypass_unit_pkg::*;
(
  input  logic                use_i,
  input  logic [RegAddrW-1:0] src_i,
  input  haz_slot_t           exe_i,
  input  haz_slot_t           mem_i,
  input  haz_slot_t           wb_i,
  output logic                dep_o,
  output bypass_sel_e         sel_o,
  output logic                late_stall_o
);

  logic hit_exe, hit_mem, hit_wb;
  logic unused_wb_late;

  // A WB result is always ready, so its late flag never matters.
  assign unused_wb_late = wb_i.late;

  always_comb begin
    hit_exe      = use_i && slot_hit(exe_i, src_i);
    hit_mem      = use_i && slot_hit(mem_i, src_i);
    hit_wb       = use_i && slot_hit(wb_i, src_i);
    dep_o        = hit_exe || hit_mem || hit_wb;
    sel_o        = SEL_RF;
    late_stall_o = 1'b0;
    if (hit_exe) begin
      sel_o        = SEL_EXE;
      late_stall_o = exe_i.late;
    end else if (hit_mem) begin
      sel_o        = SEL_MEM;
      late_stall_o = mem_i.late;
    end else if (hit_wb) begin
      sel_o        = SEL_WB;
    end
  end

endmodule

// File: rtl/hazard_bypass_unit.sv
// Hazard detection and bypass select generation between decode and the EXE operand muxes.
// Tracks producers in EXE/MEM/WB, owns multiply occupancy of EXE, and raises the decode stall.
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding; without it every
// in-flight match stalls decode and operands always come from the (write-before-read) regfile.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   id_*_i                 : decode-stage instruction fields
//   flush_i                : kill decode, EXE and MEM contents
//   stall_o                : hold fetch/decode
//   dep_src1_o/dep_src2_o  : source served by a bypass
//   byp_sel1_o/byp_sel2_o  : 00 regfile, 01 EXE, 10 MEM, 11 WB
//   mul_busy_o             : multiply occupying EXE
module hazard_bypass_unit
  import hazard_bypass_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = RegAddrW,
  parameter int unsigned MUL_LATENCY = MulLatency
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_src1_i,
  input  logic [REG_ADDR_W-1:0] id_src2_i,
  input  logic                  id_use_src1_i,
  input  logic                  id_use_src2_i,
  input  logic [REG_ADDR_W-1:0] id_dst_i,
  input  logic                  id_wr_en_i,
  input  logic                  id_late_i,
  input  logic                  id_is_mul_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  dep_src1_o,
  output logic                  dep_src2_o,
  output logic [1:0]            byp_sel1_o,
  output logic [1:0]            byp_sel2_o,
  output logic                  mul_busy_o
);

  localparam int unsigned CntW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MUL_LATENCY - 1);

  haz_slot_t exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
  haz_slot_t id_rec;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        mul_busy, issue, stall_src;
  logic        hit1, hit2, late1, late2;
  bypass_sel_e sel1_raw, sel2_raw, sel1, sel2;
  bypass_t     dep;

  assign mul_busy = (cnt_q != '0);

  hazard_src_match u_match_src1 (
    .use_i        (id_use_src1_i),
    .src_i        (RegAddrW'(id_src1_i)),
    .exe_i        (exe_q),
    .mem_i        (mem_q),
    .wb_i         (wb_q),
    .dep_o        (hit1),
    .sel_o        (sel1_raw),
    .late_stall_o (late1)
  );

  hazard_src_match u_match_src2 (
    .use_i        (id_use_src2_i),
    .src_i        (RegAddrW'(id_src2_i)),
    .exe_i        (exe_q),
    .mem_i        (mem_q),
    .wb_i         (wb_q),
    .dep_o        (hit2),
    .sel_o        (sel2_raw),
    .late_stall_o (late2)
  );

`ifdef HAZARD_FORWARDING_EN
  // Only results not yet produced (load/mul still in EXE or MEM) force a stall.
  always_comb begin
    stall_src = id_valid_i && (late1 || late2);
    dep.src1  = id_valid_i && hit1 && !late1;
    dep.src2  = id_valid_i && hit2 && !late2;
    sel1      = dep.src1 ? sel1_raw : SEL_RF;
    sel2      = dep.src2 ? sel2_raw : SEL_RF;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{late1, late2, sel1_raw, sel2_raw};

  // No forwarding paths: wait until every producer has left WB.
  always_comb begin
    stall_src = id_valid_i && (hit1 || hit2);
    dep       = '0;
    sel1      = SEL_RF;
    sel2      = SEL_RF;
  end
`endif

  assign stall_o    = mul_busy || stall_src;
  assign issue      = id_valid_i && !stall_o && !flush_i;
  assign dep_src1_o = dep.src1;
  assign dep_src2_o = dep.src2;
  assign byp_sel1_o = sel1;
  assign byp_sel2_o = sel2;
  assign mul_busy_o = mul_busy;

  always_comb begin
    id_rec = '{valid: 1'b1, dst: RegAddrW'(id_dst_i), wr_en: id_wr_en_i, late: id_late_i};
    exe_d  = exe_q;
    mem_d  = mem_q;
    wb_d   = mem_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      // Flush overrides a multiply hold; the old WB occupant retires normally.
      exe_d = '0;
      mem_d = '0;
      wb_d  = '0;
      cnt_d = '0;
    end else if (mul_busy) begin
      // EXE keeps the multiply, MEM sees bubbles behind it.
      mem_d = '0;
      cnt_d = cnt_q - CntW'(1);
    end else begin
      exe_d = issue ? id_rec : '0;
      mem_d = exe_q;
      cnt_d = (issue && id_is_mul_i) ? CntLoad : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_bypass_unit.sv
module tb_hazard_bypass_unit;
  import hazard_bypass_unit_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned ML = 4;
  localparam logic [1:0] RF = 2'b00, EX = 2'b01, ME = 2'b10, WB = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0, id_use1 = 1'b0, id_use2 = 1'b0;
  logic [AW-1:0] id_src1 = '0, id_src2 = '0, id_dst = '0;
  logic          id_wr_en = 1'b0, id_late = 1'b0, id_is_mul = 1'b0, flush = 1'b0;
  logic          stall, dep1, dep2, busy;
  logic [1:0]    sel1, sel2;

  always #5 clk = ~clk;

  hazard_bypass_unit #(
    .REG_ADDR_W  (AW),
    .MUL_LATENCY (ML)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid_i    (id_valid),
    .id_src1_i     (id_src1),
    .id_src2_i     (id_src2),
    .id_use_src1_i (id_use1),
    .id_use_src2_i (id_use2),
    .id_dst_i      (id_dst),
    .id_wr_en_i    (id_wr_en),
    .id_late_i     (id_late),
    .id_is_mul_i   (id_is_mul),
    .flush_i       (flush),
    .stall_o       (stall),
    .dep_src1_o    (dep1),
    .dep_src2_o    (dep2),
    .byp_sel1_o    (sel1),
    .byp_sel2_o    (sel2),
    .mul_busy_o    (busy)
  );

  typedef struct {
    string         name;
    logic          rst_n, valid, u1, u2, we, late, mul, flush;
    logic [AW-1:0] s1, s2, dst;
    logic          e_stall, e_busy, e_dep1, e_dep2;
    logic [1:0]    e_sel1, e_sel2;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t cur;
  int   checks = 0;
  int   errors = 0;

  function automatic void ins(string n, logic [AW-1:0] s1, logic u1, logic [AW-1:0] s2,
                              logic u2, logic [AW-1:0] dst, logic we, logic late, logic mul);
    cur = '{name: n, rst_n: 1'b1, valid: 1'b1, u1: u1, u2: u2, we: we, late: late, mul: mul,
            flush: 1'b0, s1: s1, s2: s2, dst: dst, e_stall: 1'b0, e_busy: 1'b0,
            e_dep1: 1'b0, e_dep2: 1'b0, e_sel1: RF, e_sel2: RF};
  endfunction

  function automatic void idl(string n);
    ins(n, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cur.valid = 1'b0;
  endfunction

  function automatic void fill(logic st, logic bz, logic d1, logic [1:0] s1, logic d2,
                               logic [1:0] s2);
    cur.e_stall = st;
    cur.e_busy  = bz;
    cur.e_dep1  = d1;
    cur.e_sel1  = s1;
    cur.e_dep2  = d2;
    cur.e_sel2  = s2;
  endfunction

  function automatic void ex(logic st, logic bz, logic d1, logic [1:0] s1, logic d2,
                             logic [1:0] s2);
    fill(st, bz, d1, s1, d2, s2);
    tbl.push_back(cur);
  endfunction

  function automatic void drain(string n);
    idl(n);
    for (int i = 0; i < 3; i++) ex(0, 0, 0, RF, 0, RF);
  endfunction

  task automatic chk(string n, string f, logic [1:0] act, logic [1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s %s got %0b want %0b", n, f, act, want);
    end
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    rst_n     = v.rst_n;
    id_valid  = v.valid;
    id_src1   = v.s1;
    id_src2   = v.s2;
    id_use1   = v.u1;
    id_use2   = v.u2;
    id_dst    = v.dst;
    id_wr_en  = v.we;
    id_late   = v.late;
    id_is_mul = v.mul;
    flush     = v.flush;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(e.name, "stall", {1'b0, stall}, {1'b0, e.e_stall});
    chk(e.name, "mul_busy", {1'b0, busy}, {1'b0, e.e_busy});
    chk(e.name, "dep1", {1'b0, dep1}, {1'b0, e.e_dep1});
    chk(e.name, "dep2", {1'b0, dep2}, {1'b0, e.e_dep2});
    chk(e.name, "sel1", sel1, e.e_sel1);
    chk(e.name, "sel2", sel2, e.e_sel2);
  endtask

  task automatic go(logic st, logic bz, logic d1, logic [1:0] s1, logic d2, logic [1:0] s2);
    fill(st, bz, d1, s1, d2, s2);
    apply(cur);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    idl("reset");
    cur.rst_n = 1'b0;
    ex(0, 0, 0, RF, 0, RF);
    ex(0, 0, 0, RF, 0, RF);

    // ALU producer followed by a dependent ALU op on both sources
    ins("add_x5", 0, 0, 0, 0, 5, 1, 0, 0);
    ex(0, 0, 0, RF, 0, RF);
    ins("add_x6_x5_x5", 5, 1, 5, 1, 6, 1, 0, 0);
`ifdef HAZARD_FORWARDING_EN
    ex(0, 0, 1, EX, 1, EX);
`else
    for (int i = 0; i < 3; i++) ex(1, 0, 0, RF, 0, RF);
    ex(0, 0, 0, RF, 0, RF);
`endif
    drain("drain_a");

    // Load-use
    ins("lw_x7", 0, 0, 0, 0, 7, 1, 1, 0);
    ex(0, 0, 0, RF, 0, RF);
    ins("add_x8_x7_x0", 7, 1, 0, 1, 8, 1, 0, 0);
`ifdef HAZARD_FORWARDING_EN
    ex(1, 0, 0, RF, 0, RF);
    ex(1, 0, 0, RF, 0, RF);
    ex(0, 0, 1, WB, 0, RF);
`else
    for (int i = 0; i < 3; i++) ex(1, 0, 0, RF, 0, RF);
    ex(0, 0, 0, RF, 0, RF);
`endif
    drain("drain_b");

    // x0 never matches
    ins("addi_x0", 0, 0, 0, 0, 0, 1, 0, 0);
    ex(0, 0, 0, RF, 0, RF);
    ins("add_x1_x0_x0", 0, 1, 0, 1, 1, 1, 0, 0);
    ex(0, 0, 0, RF, 0, RF);
    drain("drain_c");

    // Same register in EXE and MEM: youngest wins
    ins("add_x3_old", 0, 0, 0, 0, 3, 1, 0, 0);
    ex(0, 0, 0, RF, 0, RF);
    ins("add_x3_new", 0, 0, 0, 0, 3, 1, 0, 0);
    ex(0, 0, 0, RF, 0, RF);
    ins("use_x3", 3, 1, 11, 1, 4, 1, 0, 0);
`ifdef HAZARD_FORWARDING_EN
    ex(0, 0, 1, EX, 0, RF);
`else
    for (int i = 0; i < 3; i++) ex(1, 0, 0, RF, 0, RF);
    ex(0, 0, 0, RF, 0, RF);
`endif
    drain("drain_d");

    // Sources served from different stages (WB and MEM)
    ins("add_x12", 0, 0, 0, 0, 12, 1, 0, 0);
    ex(0, 0, 0, RF, 0, RF);
    ins("add_x13", 0, 0, 0, 0, 13, 1, 0, 0);
    ex(0, 0, 0, RF, 0, RF);
    ins("add_x14", 0, 0, 0, 0, 14, 1, 0, 0);
    ex(0, 0, 0, RF, 0, RF);
    ins("use_x12_x13", 12, 1, 13, 1, 16, 1, 0, 0);
`ifdef HAZARD_FORWARDING_EN
    ex(0, 0, 1, WB, 1, ME);
`else
    ex(1, 0, 0, RF, 0, RF);
    ex(1, 0, 0, RF, 0, RF);
    ex(0, 0, 0, RF, 0, RF);
`endif
    drain("drain_e");

    // Multiply occupancy and its consumer
    ins("mul_x9", 0, 0, 0, 0, 9, 1, 1, 1);
    ex(0, 0, 0, RF, 0, RF);
    ins("use_x9", 9, 1, 0, 0, 10, 1, 0, 0);
    for (int i = 0; i < int'(ML) - 1; i++) ex(1, 1, 0, RF, 0, RF);
    ex(1, 0, 0, RF, 0, RF);
    ex(1, 0, 0, RF, 0, RF);
`ifdef HAZARD_FORWARDING_EN
    ex(0, 0, 1, WB, 0, RF);
`else
    ex(1, 0, 0, RF, 0, RF);
    ex(0, 0, 0, RF, 0, RF);
`endif
    drain("drain_f");

    // Flushed decode is never issued
    ins("add_x20_flushed", 0, 0, 0, 0, 20, 1, 0, 0);
    cur.flush = 1'b1;
    ex(0, 0, 0, RF, 0, RF);
    ins("use_x20", 20, 1, 0, 0, 21, 1, 0, 0);
    ex(0, 0, 0, RF, 0, RF);
    drain("drain_g");

    foreach (tbl[i]) apply(tbl[i]);

    // Flush during a multiply
    ins("fl_mul_x9", 0, 0, 0, 0, 9, 1, 1, 1);
    go(0, 0, 0, RF, 0, RF);
    idl("fl_busy");
    go(1, 1, 0, RF, 0, RF);
    idl("fl_flush");
    cur.flush = 1'b1;
    go(1, 1, 0, RF, 0, RF);
    ins("fl_use_x9", 9, 1, 0, 0, 10, 1, 0, 0);
    go(0, 0, 0, RF, 0, RF);
    idl("fl_drain");
    for (int i = 0; i < 3; i++) go(0, 0, 0, RF, 0, RF);

    // Reset during a multiply
    ins("rs_mul_x9", 0, 0, 0, 0, 9, 1, 1, 1);
    go(0, 0, 0, RF, 0, RF);
    idl("rs_busy");
    go(1, 1, 0, RF, 0, RF);
    idl("rs_assert");
    cur.rst_n = 1'b0;
    go(1, 1, 0, RF, 0, RF);
    ins("rs_use_x9_in_reset", 9, 1, 9, 1, 10, 1, 0, 0);
    cur.rst_n = 1'b0;
    go(0, 0, 0, RF, 0, RF);
    ins("rs_use_x9_after", 9, 1, 9, 1, 10, 1, 0, 0);
    go(0, 0, 0, RF, 0, RF);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty got %0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
